// File: rtl/ex_stage_sequencer.sv
// ex_stage_sequencer: execute-stage issue controller with MUL stall, CMP->jump interlock, flags and jump flush
module ex_stage_sequencer #(
  parameter int MUL_CYCLES   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  output logic       id_ready,
  input  logic [5:0] id_opcode,
  input  logic [3:0] id_wb_reg,
  input  logic [3:0] stf_value,
  input  logic [3:0] alu_flags,
  output logic       ex_valid,
  output logic [3:0] alu_ctl,
  output logic       alu_start,
  output logic       wb_en,
  output logic [3:0] wb_reg,
  output logic       branch_taken,
  output logic       flush,
  output logic [3:0] flags,
  output logic       busy
);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_MUL   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam int CW = $clog2(MUL_CYCLES + FLUSH_CYCLES + 1);
  localparam logic [5:0] OP_MUL = 6'd2;
  localparam logic [5:0] OP_CMP = 6'd12;
  localparam logic [5:0] OP_STF = 6'd28;
  localparam logic [3:0] CTL_CMP  = 4'd12;
  localparam logic [3:0] CTL_PASS = 4'd13;
  localparam logic [3:0] CTL_NOP  = 4'd15;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic [3:0]    r_mul_reg;
  logic          r_ex_valid;
  logic [3:0]    r_alu_ctl;
  logic          r_alu_start;
  logic          r_wb_en;
  logic [3:0]    r_wb_reg;
  logic          r_branch;
  logic          r_flush;
  logic [3:0]    r_flags;
  logic          w_alu;
  logic          w_ld;
  logic          w_st;
  logic          w_jmp;
  logic          w_mul;
  logic          w_stf;
  logic          w_acc;
  logic          w_taken;
  logic          w_cmp_in_ex;
  logic [3:0]    w_ctl;
  logic [7:0]    w_conds;
  // Opcode classes: 0..11 are ALU ops whose code equals the ALU control, 32..39 are jumps
  assign w_alu  = id_opcode < 6'd12;
  assign w_ld   = id_opcode inside {[6'd16:6'd20]};
  assign w_st   = id_opcode inside {[6'd24:6'd26]};
  assign w_jmp  = id_opcode[5:3] == 3'b100;
  assign w_mul  = id_opcode == OP_MUL;
  assign w_stf  = id_opcode == OP_STF;
  assign w_ctl  = w_alu ? id_opcode[3:0] : (id_opcode == OP_CMP) ? CTL_CMP : (w_ld | w_st) ? CTL_PASS : CTL_NOP;
  // Flags are {C,E,L,G}; index by the low opcode bits JMP,JC,JE,JNE,JL,JLE,JG,JGE
  assign w_conds = {r_flags[0] | r_flags[2], r_flags[0], r_flags[1] | r_flags[2], r_flags[1],
                    ~r_flags[2], r_flags[2], r_flags[3], 1'b1};
  assign w_taken = w_jmp & w_conds[id_opcode[2:0]];
  // A jump directly behind a CMP must wait one cycle for the CMP flags to land
  assign w_cmp_in_ex = r_ex_valid & (r_alu_ctl == CTL_CMP);
  assign id_ready    = rst_n & r_ready & ~(w_cmp_in_ex & w_jmp);
  assign w_acc       = id_valid & id_ready;
  assign ex_valid     = r_ex_valid;
  assign alu_ctl      = r_alu_ctl;
  assign alu_start    = r_alu_start;
  assign wb_en        = r_wb_en;
  assign wb_reg       = r_wb_reg;
  assign branch_taken = r_branch;
  assign flush        = r_flush;
  assign flags        = r_flags;
  assign busy         = r_state != S_RUN;
  // Issue, flags update and RUN/MUL_WAIT/FLUSH sequencing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_mul_reg   <= '0;
      r_ex_valid  <= 1'b0;
      r_alu_ctl   <= CTL_NOP;
      r_alu_start <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_reg    <= '0;
      r_branch    <= 1'b0;
      r_flush     <= 1'b0;
      r_flags     <= '0;
    end else begin
      r_ex_valid  <= w_acc;
      r_alu_ctl   <= w_acc ? w_ctl : CTL_NOP;
      r_alu_start <= w_acc & w_mul;
      r_wb_en     <= w_acc & (w_alu & ~w_mul | w_ld);
      r_wb_reg    <= w_acc ? id_wb_reg : r_wb_reg;
      r_branch    <= w_acc & w_taken;
      r_flush     <= 1'b0;
      r_flags     <= (w_acc & w_stf) ? stf_value : w_cmp_in_ex ? alu_flags : r_flags;
      case (r_state)
        S_RUN: begin
          if (w_acc & w_mul) begin
            r_state   <= S_MUL;
            r_cnt     <= CW'(MUL_CYCLES - 2);
            r_ready   <= 1'b0;
            r_mul_reg <= id_wb_reg;
          end else if (w_acc & w_taken) begin
            r_state <= S_FLUSH;
            r_cnt   <= CW'(FLUSH_CYCLES - 1);
            r_ready <= 1'b0;
            r_flush <= 1'b1;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            r_state  <= S_RUN;
            r_ready  <= 1'b1;
            r_wb_en  <= 1'b1;
            r_wb_reg <= r_mul_reg;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          if (r_cnt == '0) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
            r_flush <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage_sequencer.sv
// tb_ex_stage_sequencer: directed scenarios for the execute-stage sequencer
module tb_ex_stage_sequencer;
  localparam logic [5:0] ADD = 6'd0, MUL = 6'd2, XNOR = 6'd7, SHL = 6'd9, CMP = 6'd12;
  localparam logic [5:0] LD = 6'd16, LDPC = 6'd19, RDF = 6'd20, STR = 6'd24, STRH = 6'd25;
  localparam logic [5:0] STF = 6'd28, JMP = 6'd32, JE = 6'd34, JNE = 6'd35, NOP = 6'd63;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic       id_ready;
  logic [5:0] id_opcode = ADD;
  logic [3:0] id_wb_reg = 4'd0;
  logic [3:0] stf_value = 4'd0;
  logic [3:0] alu_flags = 4'd0;
  logic       ex_valid, alu_start, wb_en, branch_taken, flush, busy;
  logic [3:0] alu_ctl, wb_reg, flags;
  int checks = 0;
  int errors = 0;
  ex_stage_sequencer #(.MUL_CYCLES(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_wb_reg(id_wb_reg), .stf_value(stf_value),
    .alu_flags(alu_flags), .ex_valid(ex_valid), .alu_ctl(alu_ctl),
    .alu_start(alu_start), .wb_en(wb_en), .wb_reg(wb_reg),
    .branch_taken(branch_taken), .flush(flush), .flags(flags), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [5:0] op, input logic [3:0] r);
    id_valid = 1'b1;
    id_opcode = op;
    id_wb_reg = r;
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    drive(ADD, 4'd1);
    tick;
    tick;
    checks++;
    if ({ex_valid, wb_en, flush, alu_ctl, flags, id_ready} !== {3'b000, 4'd15, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got ev/wb/fl/ctl/flags/rdy %b%b%b %0d %b %b, expected 000 15 0000 0", ex_valid, wb_en, flush, alu_ctl, flags, id_ready);
    end
    rst_n = 1'b1;
    id_valid = 1'b0;
    tick;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", id_ready);
    end
  endtask
  task automatic test_single;
    drive(ADD, 4'd5);
    tick;
    checks++;
    if ({ex_valid, alu_ctl, wb_en, wb_reg} !== {1'b1, 4'd0, 1'b1, 4'd5}) begin
      errors++;
      $display("FAIL add_issue: got ev=%b ctl=%0d wb=%b reg=%0d expected 1 0 1 5", ex_valid, alu_ctl, wb_en, wb_reg);
    end
    drive(STR, 4'd7);
    tick;
    checks++;
    if ({ex_valid, alu_ctl, wb_en} !== {1'b1, 4'd13, 1'b0}) begin
      errors++;
      $display("FAIL str_issue: got ev=%b ctl=%0d wb=%b expected 1 13 0", ex_valid, alu_ctl, wb_en);
    end
    id_valid = 1'b0;
    tick;
    checks++;
    if ({ex_valid, alu_ctl, wb_en} !== {1'b0, 4'd15, 1'b0}) begin
      errors++;
      $display("FAIL idle_bubble: got ev=%b ctl=%0d wb=%b expected 0 15 0", ex_valid, alu_ctl, wb_en);
    end
  endtask
  task automatic test_opcodes;
    logic [5:0] ops  [7] = '{LD, LDPC, STRH, NOP, 6'd14, XNOR, SHL};
    logic [3:0] ctls [7] = '{4'd13, 4'd13, 4'd13, 4'd15, 4'd15, 4'd7, 4'd9};
    logic       wbs  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], 4'(i));
      tick;
      checks++;
      if ({ex_valid, alu_ctl, wb_en} !== {1'b1, ctls[i], wbs[i]}) begin
        errors++;
        $display("FAIL opcode_map op=%0d: got ev=%b ctl=%0d wb=%b expected 1 %0d %b", ops[i], ex_valid, alu_ctl, wb_en, ctls[i], wbs[i]);
      end
    end
    id_valid = 1'b0;
    tick;
  endtask
  task automatic test_mul;
    drive(MUL, 4'd3);
    tick;
    drive(MUL, 4'd9);
    checks++;
    if ({alu_start, alu_ctl, wb_en, id_ready, busy} !== {1'b1, 4'd2, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mul_start: got st=%b ctl=%0d wb=%b rdy=%b busy=%b expected 1 2 0 0 1", alu_start, alu_ctl, wb_en, id_ready, busy);
    end
    for (int c = 2; c <= 3; c++) begin
      tick;
      checks++;
      if ({alu_start, ex_valid, wb_en, id_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL mul_wait_c%0d: got st/ev/wb/rdy %b%b%b%b expected 0000", c, alu_start, ex_valid, wb_en, id_ready);
      end
    end
    tick;
    checks++;
    if ({wb_en, wb_reg, id_ready, busy} !== {1'b1, 4'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mul_writeback: got wb=%b reg=%0d rdy=%b busy=%b expected 1 3 1 0", wb_en, wb_reg, id_ready, busy);
    end
    tick;
    id_valid = 1'b0;
    checks++;
    if ({alu_start, wb_en, id_ready} !== 3'b100) begin
      errors++;
      $display("FAIL mul_back_to_back: got st/wb/rdy %b%b%b expected 100", alu_start, wb_en, id_ready);
    end
    tick;
    tick;
    tick;
    checks++;
    if ({wb_en, wb_reg} !== {1'b1, 4'd9}) begin
      errors++;
      $display("FAIL mul2_writeback: got wb=%b reg=%0d expected 1 9", wb_en, wb_reg);
    end
    tick;
  endtask
  task automatic test_cmp_jump;
    drive(CMP, 4'd0);
    tick;
    alu_flags = 4'b0001;
    drive(ADD, 4'd2);
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmp_nonjump_ready: got %b expected 1", id_ready);
    end
    tick;
    alu_flags = 4'b0000;
    drive(CMP, 4'd0);
    checks++;
    if ({alu_ctl, wb_en, flags} !== {4'd0, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL cmp_flags_add: got ctl=%0d wb=%b flags=%b expected 0 1 0001", alu_ctl, wb_en, flags);
    end
    tick;
    alu_flags = 4'b0100;
    drive(JE, 4'd0);
    checks++;
    if ({ex_valid, alu_ctl, wb_en, id_ready} !== {1'b1, 4'd12, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL cmp_interlock: got ev=%b ctl=%0d wb=%b rdy=%b expected 1 12 0 0", ex_valid, alu_ctl, wb_en, id_ready);
    end
    tick;
    alu_flags = 4'b0000;
    checks++;
    if ({ex_valid, id_ready, flags} !== {1'b0, 1'b1, 4'b0100}) begin
      errors++;
      $display("FAIL je_accept: got ev=%b rdy=%b flags=%b expected 0 1 0100", ex_valid, id_ready, flags);
    end
    tick;
    id_valid = 1'b0;
    checks++;
    if ({branch_taken, flush, alu_ctl, wb_en, id_ready} !== {1'b1, 1'b1, 4'd15, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL je_taken: got bt=%b fl=%b ctl=%0d wb=%b rdy=%b expected 1 1 15 0 0", branch_taken, flush, alu_ctl, wb_en, id_ready);
    end
    tick;
    checks++;
    if ({branch_taken, flush, id_ready} !== 3'b010) begin
      errors++;
      $display("FAIL flush_hold: got bt/fl/rdy %b%b%b expected 010", branch_taken, flush, id_ready);
    end
    tick;
    drive(JNE, 4'd0);
    checks++;
    if ({flush, id_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL flush_end: got fl/rdy/busy %b%b%b expected 010", flush, id_ready, busy);
    end
    tick;
    id_valid = 1'b0;
    checks++;
    if ({ex_valid, branch_taken, flush, id_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL jne_not_taken: got ev/bt/fl/rdy %b%b%b%b expected 1001", ex_valid, branch_taken, flush, id_ready);
    end
    tick;
  endtask
  task automatic test_stf_jump;
    stf_value = 4'b1010;
    drive(STF, 4'd0);
    tick;
    drive(JNE, 4'd0);
    checks++;
    if ({flags, alu_ctl, wb_en} !== {4'b1010, 4'd15, 1'b0}) begin
      errors++;
      $display("FAIL stf_flags: got flags=%b ctl=%0d wb=%b expected 1010 15 0", flags, alu_ctl, wb_en);
    end
    tick;
    drive(RDF, 4'd6);
    checks++;
    if ({branch_taken, flush} !== 2'b11) begin
      errors++;
      $display("FAIL jne_taken: got bt/fl %b%b expected 11", branch_taken, flush);
    end
    tick;
    checks++;
    if ({ex_valid, flush} !== 2'b01) begin
      errors++;
      $display("FAIL flush_blocks_rdf: got ev/fl %b%b expected 01", ex_valid, flush);
    end
    tick;
    tick;
    id_valid = 1'b0;
    checks++;
    if ({ex_valid, alu_ctl, wb_en, wb_reg} !== {1'b1, 4'd13, 1'b1, 4'd6}) begin
      errors++;
      $display("FAIL rdf_after_flush: got ev=%b ctl=%0d wb=%b reg=%0d expected 1 13 1 6", ex_valid, alu_ctl, wb_en, wb_reg);
    end
    drive(JMP, 4'd0);
    tick;
    id_valid = 1'b0;
    checks++;
    if ({branch_taken, flush} !== 2'b11) begin
      errors++;
      $display("FAIL jmp_taken: got bt/fl %b%b expected 11", branch_taken, flush);
    end
    tick;
    tick;
  endtask
  task automatic test_reset_mid_mul;
    drive(MUL, 4'd11);
    tick;
    id_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    checks++;
    if ({ex_valid, wb_en, alu_start, alu_ctl, busy, id_ready, flags} !== {3'b000, 4'd15, 2'b00, 4'd0}) begin
      errors++;
      $display("FAIL reset_mid_mul: got ev/wb/st=%b%b%b ctl=%0d busy=%b rdy=%b flags=%b expected 000 15 0 0 0000", ex_valid, wb_en, alu_start, alu_ctl, busy, id_ready, flags);
    end
    rst_n = 1'b1;
    for (int c = 4; c <= 6; c++) begin
      tick;
      checks++;
      if (wb_en !== 1'b0) begin
        errors++;
        $display("FAIL aborted_mul_wb_c%0d: got %b expected 0", c, wb_en);
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_opcodes;
    test_mul;
    test_cmp_jump;
    test_stf_jump;
    test_reset_mid_mul;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
